// File: rtl/bus_transfer_sequencer_pkg.sv
// rtl/bus_transfer_sequencer_pkg.sv - shared constants, FSM state and command record
package bus_xfer_pkg;

    localparam int NUM_SRC_DEF    = 24;
    localparam int NUM_DST_DEF    = 24;
    localparam int SEL_W_DEF      = 5;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2
    } xfer_state_t;

    typedef struct packed {
        logic [SEL_W_DEF-1:0] src;
        logic [SEL_W_DEF-1:0] dst;
    } xfer_cmd_t;

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// rtl/bus_transfer_sequencer_if.sv - command handshake and bus-control signal bundle
interface bus_transfer_sequencer_if
    import bus_xfer_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int NUM_DST = NUM_DST_DEF,
    parameter int CNT_W   = CNT_W_DEF
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [SEL_W-1:0]   cmd_src;
    logic [SEL_W-1:0]   cmd_dst;
    logic [SEL_W-1:0]   bus_select;
    logic               bus_drive;
    logic [NUM_DST-1:0] load_en;
    logic               done;
    logic               busy;
    logic               err_illegal;
    logic [CNT_W-1:0]   xfer_count;

    modport slave (
        input  cmd_valid, cmd_src, cmd_dst,
        output cmd_ready, bus_select, bus_drive, load_en, done, busy,
               err_illegal, xfer_count
    );

    modport master (
        output cmd_valid, cmd_src, cmd_dst,
        input  cmd_ready, bus_select, bus_drive, load_en, done, busy,
               err_illegal, xfer_count
    );

endinterface

// File: rtl/bus_transfer_sequencer_fifo.sv
// rtl/bus_transfer_sequencer_fifo.sv - small synchronous FIFO of transfer commands
module xfer_cmd_fifo
    import bus_xfer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      clear_n,
    input  logic      push,
    input  xfer_cmd_t push_data,
    input  logic      pop,
    output xfer_cmd_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    xfer_cmd_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if a caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/bus_transfer_sequencer.sv
// rtl/bus_transfer_sequencer.sv - issues queued register-to-register bus transfers
module bus_transfer_sequencer
    import bus_xfer_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int NUM_DST    = NUM_DST_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    clear_n,
    bus_transfer_sequencer_if.slave bus
);

    localparam logic [SEL_W:0]     SRC_LIMIT = NUM_SRC[SEL_W:0];
    localparam logic [SEL_W:0]     DST_LIMIT = NUM_DST[SEL_W:0];
    localparam logic [NUM_DST-1:0] DST_ONE   = {{(NUM_DST-1){1'b0}}, 1'b1};

    xfer_state_t        state_q, state_d;
    xfer_cmd_t          cur_q, cur_d;
    xfer_cmd_t          head;
    xfer_cmd_t          push_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               illegal;
    logic               push;
    logic               pop;

    logic [SEL_W-1:0]   bus_select_q, bus_select_d;
    logic               bus_drive_q, bus_drive_d;
    logic [NUM_DST-1:0] load_en_q, load_en_d;
    logic               done_q, done_d;
    logic               err_q;
    logic [CNT_W-1:0]   count_q, count_d;

    // Illegal commands complete the handshake but never reach the FIFO.
    assign accept    = bus.cmd_valid && !fifo_full;
    assign illegal   = ({1'b0, bus.cmd_src} >= SRC_LIMIT) || ({1'b0, bus.cmd_dst} >= DST_LIMIT);
    assign push      = accept && !illegal;
    assign push_data = '{src: bus.cmd_src, dst: bus.cmd_dst};

    xfer_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clear_n   (clear_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        pop          = 1'b0;
        bus_select_d = '0;
        bus_drive_d  = 1'b0;
        load_en_d    = '0;
        done_d       = 1'b0;
        count_d      = count_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    cur_d        = head;
                    state_d      = DRIVE;
                    bus_select_d = head.src;
                    bus_drive_d  = 1'b1;
                end
            end
            DRIVE: begin
                state_d      = LOAD;
                bus_select_d = cur_q.src;
                load_en_d    = DST_ONE << cur_q.dst;
                done_d       = 1'b1;
            end
            LOAD: begin
                count_d = count_q + 1'b1;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    cur_d        = head;
                    state_d      = DRIVE;
                    bus_select_d = head.src;
                    bus_drive_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            bus_select_q <= '0;
            bus_drive_q  <= 1'b0;
            load_en_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            bus_select_q <= bus_select_d;
            bus_drive_q  <= bus_drive_d;
            load_en_q    <= load_en_d;
            done_q       <= done_d;
            err_q        <= accept && illegal;
            count_q      <= count_d;
        end
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.busy        = (state_q != IDLE) || !fifo_empty;
    assign bus.bus_select  = bus_select_q;
    assign bus.bus_drive   = bus_drive_q;
    assign bus.load_en     = load_en_q;
    assign bus.done        = done_q;
    assign bus.err_illegal = err_q;
    assign bus.xfer_count  = count_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb/tb_bus_transfer_sequencer.sv - self-checking bench for bus_transfer_sequencer
module tb_bus_transfer_sequencer;

    localparam int CW    = 10;
    localparam int NSRC  = 24;
    localparam int NDST  = 24;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0] src;
        logic [4:0] dst;
    } cmd_t;

    typedef struct packed {
        logic [4:0]  src;
        logic [4:0]  dst;
        logic        exp_err;
        logic [23:0] exp_load;
    } vec_t;

    logic clk = 1'b0;
    logic clear_n;
    int   checks = 0;
    int   passed = 0;
    int   cnt_exp = 0;
    bit   saw_full = 0;

    always #5 clk = ~clk;

    bus_transfer_sequencer_if #(.SEL_W(5), .NUM_DST(NDST), .CNT_W(CW)) bif ();

    bus_transfer_sequencer #(
        .NUM_SRC    (NSRC),
        .NUM_DST    (NDST),
        .SEL_W      (5),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bif)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level reference: accepted-but-undriven commands, loads completed.
    cmd_t        q[$];
    cmd_t        cur;
    bit          was_drive = 0;
    bit          exp_drive = 0;
    bit          exp_err = 0;
    int unsigned loads = 0;

    always @(negedge clk) begin
        if (!clear_n) begin
            q.delete();
            was_drive = 0;
            exp_drive = 0;
            exp_err   = 0;
            loads     = 0;
            check("rst_sel", bif.bus_select, 0);
            check("rst_drive", bif.bus_drive, 0);
            check("rst_load", bif.load_en, 0);
            check("rst_done", bif.done, 0);
            check("rst_err", bif.err_illegal, 0);
            check("rst_count", bif.xfer_count, 0);
            check("rst_busy", bif.busy, 0);
        end else begin
            check("m_drive_timing", bif.bus_drive, exp_drive);
            check("m_err_pulse", bif.err_illegal, exp_err);
            exp_err = 0;
            if (bif.bus_drive) begin
                if (q.size() == 0) begin
                    check("m_drive_without_cmd", 1, 0);
                end else begin
                    cur = q.pop_front();
                    check("m_drive_sel", bif.bus_select, cur.src);
                end
            end
            if (was_drive) begin
                check("m_load_en", bif.load_en, longint'(1) << cur.dst);
                check("m_load_done", bif.done, 1);
                check("m_load_sel", bif.bus_select, cur.src);
                check("m_load_nodrive", bif.bus_drive, 0);
            end else begin
                check("m_no_load", bif.load_en, 0);
                check("m_no_done", bif.done, 0);
                if (!bif.bus_drive) check("m_idle_sel", bif.bus_select, 0);
            end
            check("m_count", bif.xfer_count, loads % (1 << CW));
            check("m_ready", bif.cmd_ready, q.size() < DEPTH);
            check("m_busy", bif.busy, (q.size() > 0) || bif.bus_drive || was_drive);
            if (!bif.cmd_ready) saw_full = 1;
            if (was_drive) loads++;
            was_drive = bif.bus_drive;
            exp_drive = !bif.bus_drive && (q.size() > 0);
            if (bif.cmd_valid && bif.cmd_ready) begin
                if (bif.cmd_src < NSRC && bif.cmd_dst < NDST)
                    q.push_back('{src: bif.cmd_src, dst: bif.cmd_dst});
                else
                    exp_err = 1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [4:0] s, input logic [4:0] d);
        int n = 0;
        bif.cmd_valid = 1'b1;
        bif.cmd_src   = s;
        bif.cmd_dst   = d;
        @(negedge clk);
        while (!bif.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bif.busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_idx(input int lim);
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(lim, 31));
        return 5'($urandom_range(0, lim - 1));
    endfunction

    vec_t vecs[8];
    cmd_t burst[8];

    initial begin
        vecs[0] = '{5'd21, 5'd3,  1'b0, 24'h000008};
        vecs[1] = '{5'd0,  5'd0,  1'b0, 24'h000001};
        vecs[2] = '{5'd23, 5'd23, 1'b0, 24'h800000};
        vecs[3] = '{5'd4,  5'd4,  1'b0, 24'h000010};
        vecs[4] = '{5'd24, 5'd1,  1'b1, 24'h000000};
        vecs[5] = '{5'd5,  5'd31, 1'b1, 24'h000000};
        vecs[6] = '{5'd31, 5'd24, 1'b1, 24'h000000};
        vecs[7] = '{5'd10, 5'd17, 1'b0, 24'h020000};
        burst[0] = '{5'd0,  5'd1};
        burst[1] = '{5'd5,  5'd6};
        burst[2] = '{5'd10, 5'd11};
        burst[3] = '{5'd23, 5'd12};
        burst[4] = '{5'd1,  5'd22};
        burst[5] = '{5'd2,  5'd2};
        burst[6] = '{5'd3,  5'd9};
        burst[7] = '{5'd6,  5'd20};

        clear_n = 1'b0;
        bif.cmd_valid = 1'b0;
        bif.cmd_src = '0;
        bif.cmd_dst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 clear_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", bif.cmd_ready, 1);
        check("post_reset_busy", bif.busy, 0);

        // Single commands from idle: err, DRIVE and LOAD timing.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].src, vecs[i].dst);
            @(negedge clk);
            check("vec_err", bif.err_illegal, vecs[i].exp_err);
            @(negedge clk);
            check("vec_drive", bif.bus_drive, !vecs[i].exp_err);
            check("vec_drive_sel", bif.bus_select, vecs[i].exp_err ? 5'd0 : vecs[i].src);
            @(negedge clk);
            check("vec_load_en", bif.load_en, vecs[i].exp_load);
            check("vec_done", bif.done, !vecs[i].exp_err);
            if (!vecs[i].exp_err) cnt_exp++;
            @(negedge clk);
            check("vec_count", bif.xfer_count, cnt_exp % (1 << CW));
            check("vec_idle_sel", bif.bus_select, 0);
            @(posedge clk);
            #1;
        end

        // Back-to-back burst fills the FIFO.
        saw_full = 0;
        for (int i = 0; i < 8; i++) begin
            send(burst[i].src, burst[i].dst);
            cnt_exp++;
        end
        wait_idle();
        check("burst_saw_full", saw_full, 1);
        check("burst_count", bif.xfer_count, cnt_exp % (1 << CW));

        // src==dst, then a push landing during LOAD chains straight into DRIVE.
        send(5'd4, 5'd4);
        @(posedge clk);
        #1;
        send(5'd9, 5'd12);
        @(negedge clk);
        check("chain_load_en", bif.load_en, 24'h000010);
        @(negedge clk);
        check("chain_drive", bif.bus_drive, 1);
        check("chain_sel", bif.bus_select, 9);
        cnt_exp += 2;
        wait_idle();
        check("chain_count", bif.xfer_count, cnt_exp % (1 << CW));

        // Asynchronous reset in the middle of a DRIVE.
        send(5'd7, 5'd2);
        @(posedge clk);
        #2;
        check("abort_in_drive", bif.bus_drive, 1);
        clear_n = 1'b0;
        #1;
        check("abort_drive_low", bif.bus_drive, 0);
        check("abort_sel_low", bif.bus_select, 0);
        check("abort_count_low", bif.xfer_count, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_load2", bif.load_en[2], 0);
        end
        #2 clear_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", bif.cmd_ready, 1);
        check("abort_busy", bif.busy, 0);
        cnt_exp = 0;

        // Counter wrap: bring it to all-ones, then one more transfer.
        while (cnt_exp % (1 << CW) != (1 << CW) - 1) begin
            send(5'($urandom_range(0, NSRC - 1)), 5'($urandom_range(0, NDST - 1)));
            cnt_exp++;
        end
        wait_idle();
        check("wrap_all_ones", bif.xfer_count, (1 << CW) - 1);
        send(5'd1, 5'd2);
        cnt_exp++;
        wait_idle();
        check("wrap_zero", bif.xfer_count, 0);

        // Random traffic with gaps and occasional illegal commands.
        for (int i = 0; i < 300; i++) begin
            logic [4:0] s;
            logic [4:0] d;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            s = rnd_idx(NSRC);
            d = rnd_idx(NDST);
            send(s, d);
            if (s < NSRC && d < NDST) cnt_exp++;
        end
        wait_idle();
        check("rand_final_count", bif.xfer_count, cnt_exp % (1 << CW));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
